// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch front end with a small in-order queue.
// Issues one imem request at a time from a fetch PC, tags each request with a
// redirect epoch, and buffers returned instructions for decode.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ex_take_branch_out           redirect request from execute
//   ex_target_PC_out [XLEN]      redirect target (low two bits ignored)
//   proc2Imem_req / _addr        fetch request valid / word-aligned address
//   Imem2proc_valid / _data      fetch response (one per request)
//   id_ready                     decode takes the head entry this cycle
//   if_valid_inst_out            head entry valid
//   if_PC_out/if_NPC_out/if_IR_out  head PC, PC+4, instruction
//   if_count_out                 queue occupancy

`ifndef NOOP_INST
`define NOOP_INST 32'h0000_0013
`endif

module if_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_take_branch_out,
  input  logic [XLEN-1:0]        ex_target_PC_out,
  output logic                   proc2Imem_req,
  output logic [XLEN-1:0]        proc2Imem_addr,
  input  logic                   Imem2proc_valid,
  input  logic [XLEN-1:0]        Imem2proc_data,
  input  logic                   id_ready,
  output logic                   if_valid_inst_out,
  output logic [XLEN-1:0]        if_PC_out,
  output logic [XLEN-1:0]        if_NPC_out,
  output logic [XLEN-1:0]        if_IR_out,
  output logic [$clog2(DEPTH):0] if_count_out
);

  localparam int unsigned     PW         = $clog2(DEPTH);
  localparam int unsigned     CW         = PW + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));
  localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

  // Architectural state
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic            pend_q, pend_d;
  logic            epoch_q, epoch_d;
  logic            tag_q, tag_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;

  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] ir_mem_q [DEPTH];

  logic            has_head_c;
  logic [CW-1:0]   occ_c;
  logic            issue_c;
  logic            rsp_c;
  logic            enq_c;
  logic            deq_c;

  // Handshake qualifiers; redirect and reset dominate every queue action
  assign has_head_c = (count_q != '0);
  assign occ_c      = count_q + CW'(pend_q);
  assign issue_c    = !rst && !pend_q && (occ_c < CW'(DEPTH)) && !ex_take_branch_out;
  assign rsp_c      = !rst && Imem2proc_valid && pend_q;
  assign enq_c      = rsp_c && (tag_q == epoch_q) && !ex_take_branch_out;
  assign deq_c      = !rst && has_head_c && id_ready && !ex_take_branch_out;

  // Next-state logic
  always_comb begin
    fpc_d     = fpc_q;
    pend_d    = pend_q;
    epoch_d   = epoch_q;
    tag_d     = tag_q;
    req_pc_d  = req_pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    last_pc_d = has_head_c ? pc_mem_q[head_q] : last_pc_q;

    if (issue_c) begin
      pend_d   = 1'b1;
      tag_d    = epoch_q;
      req_pc_d = fpc_q;
      fpc_d    = fpc_q + INST_BYTES;
    end else if (rsp_c) begin
      pend_d = 1'b0;
    end

    if (ex_take_branch_out) begin
      fpc_d   = ex_target_PC_out & ALIGN_MASK;
      epoch_d = ~epoch_q;
      // Retag the in-flight request with the old epoch so it stays stale even
      // if further redirects flip the epoch back before it returns.
      tag_d   = epoch_q;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_c) tail_d = tail_q + PW'(1);
      if (deq_c) head_d = head_q + PW'(1);
      count_d = count_q + CW'(enq_c) - CW'(deq_c);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q     <= RESET_PC & ALIGN_MASK;
      pend_q    <= 1'b0;
      epoch_q   <= 1'b0;
      tag_q     <= 1'b0;
      req_pc_q  <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      last_pc_q <= RESET_PC;
    end else begin
      fpc_q     <= fpc_d;
      pend_q    <= pend_d;
      epoch_q   <= epoch_d;
      tag_q     <= tag_d;
      req_pc_q  <= req_pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  // Queue storage; contents are only meaningful under count_q
  always_ff @(posedge clk) begin
    if (enq_c) begin
      pc_mem_q[tail_q] <= req_pc_q;
      ir_mem_q[tail_q] <= Imem2proc_data;
    end
  end

  assign proc2Imem_req     = issue_c;
  assign proc2Imem_addr    = fpc_q & ALIGN_MASK;
  assign if_valid_inst_out = !rst && has_head_c;
  assign if_count_out      = count_q;

  // Head view; an empty queue shows a NOP at the last head PC
  always_comb begin
    if_PC_out = last_pc_q;
    if_IR_out = XLEN'(`NOOP_INST);
    if (rst) begin
      if_PC_out = RESET_PC;
    end else if (has_head_c) begin
      if_PC_out = pc_mem_q[head_q];
      if_IR_out = ir_mem_q[head_q];
    end
  end

  assign if_NPC_out = if_PC_out + INST_BYTES;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue: directed scenarios plus randomized traffic
// against a queue-based reference model of the fetch stream.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        br;
  logic [31:0] tgt;
  logic        proc2Imem_req;
  logic [31:0] proc2Imem_addr;
  logic        Imem2proc_valid;
  logic [31:0] Imem2proc_data;
  logic        id_ready;
  logic        if_valid_inst_out;
  logic [31:0] if_PC_out;
  logic [31:0] if_NPC_out;
  logic [31:0] if_IR_out;
  logic [2:0]  if_count_out;

  if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_take_branch_out(br),
    .ex_target_PC_out  (tgt),
    .proc2Imem_req     (proc2Imem_req),
    .proc2Imem_addr    (proc2Imem_addr),
    .Imem2proc_valid   (Imem2proc_valid),
    .Imem2proc_data    (Imem2proc_data),
    .id_ready          (id_ready),
    .if_valid_inst_out (if_valid_inst_out),
    .if_PC_out         (if_PC_out),
    .if_NPC_out        (if_NPC_out),
    .if_IR_out         (if_IR_out),
    .if_count_out      (if_count_out)
  );

  always #5 clk = ~clk;

  // Reference model: the ordered list of fetched-but-undecoded instructions
  typedef struct packed { logic [31:0] pc; logic [31:0] ir; } ent_t;
  ent_t        mq[$];
  logic        m_out   = 1'b0;
  logic        m_stale = 1'b0;
  logic [31:0] m_pc    = RESET_PC;
  logic [31:0] m_req_pc = RESET_PC;
  logic [31:0] m_last  = RESET_PC;

  int n_cmp = 0;
  int n_bad = 0;

  // Instruction memory responder
  int          fixed_lat = 1;
  logic        im_pend   = 1'b0;
  logic [31:0] im_addr   = '0;
  int          im_wait   = 0;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
  endfunction

  function automatic void model_update();
    logic e_req;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_out = 1'b0; m_stale = 1'b0;
      m_pc = RESET_PC; m_last = RESET_PC;
      return;
    end
    e_req = !m_out && (mq.size() < int'(DEPTH)) && !br;
    if (mq.size() != 0) m_last = mq[0].pc;
    if (br) begin
      if (m_out && Imem2proc_valid) begin
        m_out = 1'b0; m_stale = 1'b0;
      end else if (m_out) begin
        m_stale = 1'b1;
      end
      mq.delete();
      m_pc = tgt & 32'hFFFF_FFFC;
    end else begin
      if (id_ready && mq.size() != 0) void'(mq.pop_front());
      if (m_out && Imem2proc_valid) begin
        if (!m_stale) begin
          e.pc = m_req_pc; e.ir = Imem2proc_data;
          mq.push_back(e);
        end
        m_out = 1'b0; m_stale = 1'b0;
      end
      if (e_req) begin
        m_out = 1'b1; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  // Advance one clock: update model, let imem capture requests, drive responses
  task automatic tick();
    model_update();
    if (proc2Imem_req) begin
      im_pend = 1'b1;
      im_addr = proc2Imem_addr;
      im_wait = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(3, 1));
    end else if (Imem2proc_valid) begin
      im_pend = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    Imem2proc_valid = 1'b0;
    Imem2proc_data  = $urandom;
    if (im_pend) begin
      im_wait--;
      if (im_wait <= 0) begin
        Imem2proc_valid = 1'b1;
        Imem2proc_data  = imem_word(im_addr);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; br = 1'b0;
    for (int i = 0; i < 4; i++) begin #1; tick(); end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; br = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (proc2Imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req cyc%0d: got %b want 0", i, proc2Imem_req); end
      n_cmp++; if (if_valid_inst_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid cyc%0d: got %b want 0", i, if_valid_inst_out); end
      n_cmp++; if (if_IR_out !== NOOP) begin n_bad++; $display("FAIL rst_ir cyc%0d: got %h want %h", i, if_IR_out, NOOP); end
      n_cmp++; if (if_PC_out !== RESET_PC) begin n_bad++; $display("FAIL rst_pc cyc%0d: got %h want %h", i, if_PC_out, RESET_PC); end
      n_cmp++; if (if_NPC_out !== RESET_PC + 32'd4) begin n_bad++; $display("FAIL rst_npc cyc%0d: got %h want %h", i, if_NPC_out, RESET_PC + 32'd4); end
      if (i > 0) begin
        n_cmp++; if (if_count_out !== 3'd0) begin n_bad++; $display("FAIL rst_count cyc%0d: got %0d want 0", i, if_count_out); end
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_stream();
    fixed_lat = 1; id_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (proc2Imem_req !== (i % 2 == 0)) begin n_bad++; $display("FAIL stream_req cyc%0d: got %b want %b", i, proc2Imem_req, (i % 2 == 0)); end
      if (i % 2 == 0) begin
        n_cmp++; if (proc2Imem_addr !== 32'(i * 2)) begin n_bad++; $display("FAIL stream_addr cyc%0d: got %h want %h", i, proc2Imem_addr, 32'(i * 2)); end
      end
      n_cmp++; if (if_valid_inst_out !== (i >= 2 && i % 2 == 0)) begin n_bad++; $display("FAIL stream_valid cyc%0d: got %b", i, if_valid_inst_out); end
      if (i >= 2 && i % 2 == 0) begin
        n_cmp++; if (if_PC_out !== 32'((i - 2) * 2)) begin n_bad++; $display("FAIL stream_pc cyc%0d: got %h want %h", i, if_PC_out, 32'((i - 2) * 2)); end
        n_cmp++; if (if_IR_out !== imem_word(32'((i - 2) * 2))) begin n_bad++; $display("FAIL stream_ir cyc%0d: got %h want %h", i, if_IR_out, imem_word(32'((i - 2) * 2))); end
      end
      tick();
    end
  endtask

  task automatic test_fill();
    fixed_lat = 1; id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if (proc2Imem_req !== (i % 2 == 0 && i <= 6)) begin n_bad++; $display("FAIL fill_req cyc%0d: got %b", i, proc2Imem_req); end
      tick();
    end
    #1;
    n_cmp++; if (if_count_out !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d want 4", if_count_out); end
    n_cmp++; if (proc2Imem_req !== 1'b0) begin n_bad++; $display("FAIL fill_full_req: got %b want 0", proc2Imem_req); end
    tick();
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (if_valid_inst_out !== 1'b1) begin n_bad++; $display("FAIL drain_valid k%0d: got %b want 1", k, if_valid_inst_out); end
      n_cmp++; if (if_PC_out !== 32'(k * 4)) begin n_bad++; $display("FAIL drain_pc k%0d: got %h want %h", k, if_PC_out, 32'(k * 4)); end
      tick();
    end
  endtask

  task automatic test_redirect_pending();
    logic found;
    fixed_lat = 1; id_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (proc2Imem_req && proc2Imem_addr == 32'h8) found = 1'b1;
      else tick();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rpend_find: got no request at 0x8 within 20 cycles"); end
    fixed_lat = 2;
    tick();
    br = 1'b1; tgt = 32'h100;
    #1;
    n_cmp++; if (proc2Imem_req !== 1'b0) begin n_bad++; $display("FAIL rpend_req_br: got %b want 0", proc2Imem_req); end
    tick();
    br = 1'b0; fixed_lat = 1;
    #1;
    n_cmp++; if (proc2Imem_req !== 1'b0) begin n_bad++; $display("FAIL rpend_req_stale: got %b want 0", proc2Imem_req); end
    n_cmp++; if (if_valid_inst_out !== 1'b0) begin n_bad++; $display("FAIL rpend_valid: got %b want 0", if_valid_inst_out); end
    n_cmp++; if (if_count_out !== 3'd0) begin n_bad++; $display("FAIL rpend_count: got %0d want 0", if_count_out); end
    tick();
    #1;
    n_cmp++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h100) begin n_bad++; $display("FAIL rpend_newreq: got req %b addr %h want 1 100", proc2Imem_req, proc2Imem_addr); end
    tick();
    #1; tick();
    #1;
    n_cmp++; if (if_valid_inst_out !== 1'b1 || if_PC_out !== 32'h100) begin n_bad++; $display("FAIL rpend_first: got valid %b pc %h want 1 100", if_valid_inst_out, if_PC_out); end
    n_cmp++; if (if_IR_out !== imem_word(32'h100)) begin n_bad++; $display("FAIL rpend_ir: got %h want %h", if_IR_out, imem_word(32'h100)); end
    tick();
  endtask

  task automatic test_redirect_resp();
    fixed_lat = 1; id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin #1; tick(); end
    br = 1'b1; tgt = 32'h200; id_ready = 1'b1;
    #1;
    n_cmp++; if (if_count_out !== 3'd2 || Imem2proc_valid !== 1'b1) begin n_bad++; $display("FAIL rresp_setup: got count %0d rsp %b want 2 1", if_count_out, Imem2proc_valid); end
    tick();
    br = 1'b0; id_ready = 1'b0;
    #1;
    n_cmp++; if (if_count_out !== 3'd0) begin n_bad++; $display("FAIL rresp_count: got %0d want 0", if_count_out); end
    n_cmp++; if (if_valid_inst_out !== 1'b0 || if_IR_out !== NOOP) begin n_bad++; $display("FAIL rresp_empty: got valid %b ir %h want 0 %h", if_valid_inst_out, if_IR_out, NOOP); end
    n_cmp++; if (if_PC_out !== 32'h0 || if_NPC_out !== 32'h4) begin n_bad++; $display("FAIL rresp_hold: got pc %h npc %h want 0 4", if_PC_out, if_NPC_out); end
    n_cmp++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h200) begin n_bad++; $display("FAIL rresp_newreq: got req %b addr %h want 1 200", proc2Imem_req, proc2Imem_addr); end
    tick();
  endtask

  task automatic test_misaligned();
    fixed_lat = 1; id_ready = 1'b0;
    do_reset();
    br = 1'b1; tgt = 32'h103;
    #1;
    n_cmp++; if (proc2Imem_req !== 1'b0) begin n_bad++; $display("FAIL mis_req_br: got %b want 0", proc2Imem_req); end
    tick();
    br = 1'b0;
    #1;
    n_cmp++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h100) begin n_bad++; $display("FAIL mis_addr: got req %b addr %h want 1 100", proc2Imem_req, proc2Imem_addr); end
    tick();
    #1; tick();
    #1;
    n_cmp++; if (if_valid_inst_out !== 1'b1 || if_PC_out !== 32'h100 || if_NPC_out !== 32'h104) begin n_bad++; $display("FAIL mis_npc: got valid %b pc %h npc %h want 1 100 104", if_valid_inst_out, if_PC_out, if_NPC_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    fixed_lat = 3; id_ready = 1'b1;
    do_reset();
    #1;
    n_cmp++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h0) begin n_bad++; $display("FAIL b2b_first: got req %b addr %h want 1 0", proc2Imem_req, proc2Imem_addr); end
    tick();
    fixed_lat = 1;
    br = 1'b1; tgt = 32'h300;
    #1; tick();
    tgt = 32'h400;
    #1; tick();
    br = 1'b0;
    #1;
    n_cmp++; if (proc2Imem_req !== 1'b0 || if_valid_inst_out !== 1'b0) begin n_bad++; $display("FAIL b2b_stale: got req %b valid %b want 0 0", proc2Imem_req, if_valid_inst_out); end
    tick();
    #1;
    n_cmp++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h400) begin n_bad++; $display("FAIL b2b_req: got req %b addr %h want 1 400", proc2Imem_req, proc2Imem_addr); end
    n_cmp++; if (if_valid_inst_out !== 1'b0) begin n_bad++; $display("FAIL b2b_drop: got valid %b want 0", if_valid_inst_out); end
    tick();
    #1; tick();
    #1;
    n_cmp++; if (if_valid_inst_out !== 1'b1 || if_PC_out !== 32'h400) begin n_bad++; $display("FAIL b2b_pc: got valid %b pc %h want 1 400", if_valid_inst_out, if_PC_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    fixed_lat = 1; id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin #1; tick(); end
    fixed_lat = 2;
    #1;
    n_cmp++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'hC) begin n_bad++; $display("FAIL rmid_req: got req %b addr %h want 1 c", proc2Imem_req, proc2Imem_addr); end
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (if_count_out !== 3'd3) begin n_bad++; $display("FAIL rmid_count_pre: got %0d want 3", if_count_out); end
    n_cmp++; if (if_valid_inst_out !== 1'b0 || proc2Imem_req !== 1'b0 || if_PC_out !== RESET_PC || if_IR_out !== NOOP) begin n_bad++; $display("FAIL rmid_rst_out: got valid %b req %b pc %h ir %h", if_valid_inst_out, proc2Imem_req, if_PC_out, if_IR_out); end
    tick();
    #1;
    n_cmp++; if (if_count_out !== 3'd0) begin n_bad++; $display("FAIL rmid_count: got %0d want 0", if_count_out); end
    tick();
    #1; tick();
    #1; tick();
    rst = 1'b0; fixed_lat = 1;
    #1;
    n_cmp++; if (if_count_out !== 3'd0 || if_valid_inst_out !== 1'b0 || if_PC_out !== RESET_PC) begin n_bad++; $display("FAIL rmid_after: got count %0d valid %b pc %h", if_count_out, if_valid_inst_out, if_PC_out); end
    n_cmp++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== RESET_PC) begin n_bad++; $display("FAIL rmid_req2: got req %b addr %h", proc2Imem_req, proc2Imem_addr); end
    tick();
    #1; tick();
    #1;
    n_cmp++; if (if_count_out !== 3'd1 || if_PC_out !== RESET_PC || if_IR_out !== imem_word(RESET_PC)) begin n_bad++; $display("FAIL rmid_first: got count %0d pc %h ir %h", if_count_out, if_PC_out, if_IR_out); end
    tick();
  endtask

  task automatic test_random();
    int          rst_hold;
    logic        e_req, e_valid;
    logic [31:0] e_pc, e_ir;
    fixed_lat = 0; id_ready = 1'b1;
    do_reset();
    rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_hold > 0) begin rst = 1'b1; rst_hold--; end
      else if ($urandom_range(199, 0) == 0) begin rst = 1'b1; rst_hold = 3; end
      else rst = 1'b0;
      br = !rst && ($urandom_range(11, 0) == 0);
      tgt = $urandom;
      id_ready = (c % 400 < 200) ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
      #1;
      e_req   = !rst && !m_out && (mq.size() < int'(DEPTH)) && !br;
      e_valid = !rst && (mq.size() != 0);
      e_pc    = m_last;
      e_ir    = NOOP;
      if (rst) e_pc = RESET_PC;
      else if (mq.size() != 0) begin e_pc = mq[0].pc; e_ir = mq[0].ir; end
      n_cmp++; if (proc2Imem_req !== e_req) begin n_bad++; $display("FAIL rnd_req cyc%0d: got %b want %b", c, proc2Imem_req, e_req); end
      if (e_req) begin
        n_cmp++; if (proc2Imem_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr cyc%0d: got %h want %h", c, proc2Imem_addr, m_pc); end
      end
      n_cmp++; if (if_valid_inst_out !== e_valid) begin n_bad++; $display("FAIL rnd_valid cyc%0d: got %b want %b", c, if_valid_inst_out, e_valid); end
      n_cmp++; if (if_PC_out !== e_pc || if_NPC_out !== e_pc + 32'd4) begin n_bad++; $display("FAIL rnd_pc cyc%0d: got %h/%h want %h", c, if_PC_out, if_NPC_out, e_pc); end
      n_cmp++; if (if_IR_out !== e_ir) begin n_bad++; $display("FAIL rnd_ir cyc%0d: got %h want %h", c, if_IR_out, e_ir); end
      if (!rst) begin
        n_cmp++; if (if_count_out !== 3'(mq.size())) begin n_bad++; $display("FAIL rnd_count cyc%0d: got %0d want %0d", c, if_count_out, mq.size()); end
      end
      tick();
    end
    rst = 1'b0; br = 1'b0;
  endtask

  initial begin
    rst = 1'b1; br = 1'b0; tgt = '0; id_ready = 1'b0;
    Imem2proc_valid = 1'b0; Imem2proc_data = '0;
    test_reset();
    test_stream();
    test_fill();
    test_redirect_pending();
    test_redirect_resp();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning fetch-queue entries; power of two, >= 2.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC loaded by reset.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port ex_take_branch_out  input  1  redirect request.
REQ-007 SHALL have port ex_target_PC_out  input  XLEN  redirect target.
REQ-008 SHALL have port proc2Imem_req  output  1  fetch request valid.
REQ-009 SHALL have port proc2Imem_addr  output  XLEN  fetch address, bits [1:0] forced 0.
REQ-010 SHALL have port Imem2proc_valid  input  1  response valid, one per request, at least 1 cycle after request.
REQ-011 SHALL have port Imem2proc_data  input  XLEN  fetched instruction.
REQ-012 SHALL have port id_ready  input  1  decode accepts head entry this cycle.
REQ-013 SHALL have port if_valid_inst_out  output  1  head entry valid.
REQ-014 SHALL have port if_PC_out / if_NPC_out / if_IR_out  output  XLEN each  head PC, PC+4, instruction.
REQ-015 SHALL have port if_count_out  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 SHALL keep fetch PC register fpc; proc2Imem_addr = {fpc[XLEN-1:2],2'b0}.
REQ-017 SHALL permit at most one outstanding imem request; flag pend set on issue, cleared on response.
REQ-018 SHALL assert proc2Imem_req when !pend && (count + pend) < DEPTH && !ex_take_branch_out; fpc <= fpc+4 on issue.
REQ-019 SHALL tag each request with 1-bit epoch; epoch toggles on every redirect.
REQ-020 SHALL enqueue response {PC, PC+4, data} at tail when Imem2proc_valid && tag == epoch; mismatched-tag responses SHALL be dropped and only clear pend.
REQ-021 SHALL drive if_PC/NPC/IR from head entry; enqueued entry visible at output the cycle after the response (1-cycle latency).
REQ-022 SHALL output if_valid_inst_out = (count != 0); when 0, if_IR_out = `NOOP_INST and if_PC/NPC_out hold last head values.
REQ-023 SHALL dequeue head when if_valid_inst_out && id_ready.
REQ-024 SHALL support simultaneous enqueue and dequeue in one cycle, count unchanged.
REQ-025 SHALL never overflow: issue gating of REQ-018 guarantees space; full queue (count == DEPTH) SHALL suppress requests.
REQ-026 SHALL wrap head/tail pointers modulo DEPTH.
REQ-027 On ex_take_branch_out: fpc <= target with [1:0] cleared, queue flushed (count <= 0), epoch toggles, no request issued that cycle; redirect SHALL override same-cycle enqueue and dequeue.
REQ-028 Response arriving same cycle as redirect SHALL be dropped.
REQ-029 Redirect while pend set SHALL leave pend set until the stale response returns; new fetch starts after.
REQ-030 Back-to-back redirects SHALL each take effect; last target wins.

Reset
REQ-031 On rst: fpc <= RESET_PC, count/head/tail <= 0, pend <= 0, epoch <= 0.
REQ-032 During and the cycle of rst: proc2Imem_req = 0, if_valid_inst_out = 0, if_IR_out = `NOOP_INST, if_PC_out = RESET_PC, if_NPC_out = RESET_PC+4.
REQ-033 rst mid-transaction SHALL discard pending request; response arriving after rst with pend = 0 SHALL be ignored.

Verification
REQ-034 Reset release, 1-cycle imem, id_ready=1 -> requests at 0x0,0x4,0x8; if_PC_out 0x0 valid 2 cycles after first request, then one instruction every 2 cycles.
REQ-035 id_ready=0, DEPTH=4 -> exactly 4 entries enqueued (PC 0x0..0xC), proc2Imem_req low thereafter, count=4; id_ready=1 drains in order.
REQ-036 Request pending at 0x8, redirect to 0x100, stale response next cycle -> stale dropped, queue empty, next request addr 0x100, first valid PC 0x100.
REQ-037 Redirect same cycle as valid response and id_ready=1 -> count=0 next cycle, response not enqueued, no dequeue visible.
REQ-038 Redirect target 0x103 -> proc2Imem_addr 0x100, if_NPC_out 0x104.
REQ-039 rst asserted with count=3 and pend=1 -> next cycle count=0, valid=0, PC_out=RESET_PC; late response ignored.
